// File: rtl/inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// inst_fetch_ctrl
//   Instruction fetch front end. Keeps a byte PC, issues at most one ROM read
//   at a time (the ROM returns data one cycle after the address is captured),
//   and buffers returned {pc, opcode} pairs in a 2-entry FIFO that feeds a
//   valid/ready consumer. A redirect flushes the FIFO, drops any read in
//   flight and reloads the PC.
//
// Parameters
//   RESET_PC        byte address of the first fetch after reset
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst             asynchronous active-high reset
//   fetch_en        allows new ROM reads to issue
//   redirect_valid  one-cycle pulse loading redirect_pc as the new fetch PC
//   redirect_pc     byte address for the redirect (low two bits ignored)
//   rom_addr        word address to the instruction ROM, {2'b00, pc[31:2]}
//   rom_data        ROM opcode, valid the cycle after rom_addr was captured
//   inst_valid      an instruction is presented to the consumer
//   inst_ready      consumer accepts the presented instruction
//   inst_pc         byte PC of the presented instruction
//   inst_opcode     opcode of the presented instruction
//   perf_fetch_cnt  (FETCH_PERF_CNT_EN only) count of issued ROM reads
//   perf_stall_cnt  (FETCH_PERF_CNT_EN only) cycles with inst_valid & ~inst_ready
//
// Configuration
//   Define FETCH_PERF_CNT_EN to add the two wrapping performance counters.
// -----------------------------------------------------------------------------
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_opcode
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg;
  logic [1:0]  count_reg;
  logic        inflight_reg;
  logic [31:0] inflight_pc_reg;
  logic        wr_ptr_reg, rd_ptr_reg;
  logic [31:0] fifo_pc_reg [2];
  logic [31:0] fifo_op_reg [2];

  logic        issue, enq, deq;
  logic [2:0]  occupancy;

  // Redirect targets are word aligned; the dropped low bits are intentionally
  // not observed anywhere.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM: next-state logic. RUN is left only once the last read has landed.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fetch_en) state_next = RUN;
      RUN:     if (!fetch_en && !inflight_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs / datapath controls. Issue is not qualified by the state so
  // the first read goes out in the same cycle fetch_en rises. Occupancy looks
  // ahead at the slot freed by this cycle's dequeue so streaming runs at one
  // instruction per cycle without ever overfilling the FIFO.
  always_comb begin
    deq       = inst_valid & inst_ready;
    enq       = inflight_reg & ~redirect_valid;
    occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, deq};
    issue     = 1'b0;
    if (fetch_en && !redirect_valid && (occupancy < 3'd2)) issue = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // PC, in-flight tracking and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      count_reg       <= 2'd0;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= 32'd0;
      wr_ptr_reg      <= 1'b0;
      rd_ptr_reg      <= 1'b0;
    end else if (redirect_valid) begin
      // Flush everything; the response of a read in flight this cycle is
      // simply never enqueued.
      pc_reg       <= {redirect_pc[31:2], 2'b00};
      count_reg    <= 2'd0;
      inflight_reg <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      if (issue) begin
        pc_reg          <= pc_reg + 32'd4;
        inflight_pc_reg <= pc_reg;
      end
      inflight_reg <= issue;
      if (enq) wr_ptr_reg <= ~wr_ptr_reg;
      if (deq) rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, enq} - {1'b0, deq};
    end
  end

  // FIFO storage, one register pair per entry.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          fifo_pc_reg[gi] <= 32'd0;
          fifo_op_reg[gi] <= 32'd0;
        end else if (enq && (wr_ptr_reg == 1'(gi))) begin
          fifo_pc_reg[gi] <= inflight_pc_reg;
          fifo_op_reg[gi] <= rom_data;
        end
      end
    end
  endgenerate

  assign rom_addr    = {2'b00, pc_reg[31:2]};
  assign inst_valid  = (count_reg != 2'd0) & ~redirect_valid;
  assign inst_pc     = fifo_pc_reg[rd_ptr_reg];
  assign inst_opcode = fifo_op_reg[rd_ptr_reg];

`ifdef FETCH_PERF_CNT_EN
  // Both counters wrap naturally at 32 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= 32'd0;
      perf_stall_cnt <= 32'd0;
    end else begin
      if (issue)                    perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (inst_valid && !inst_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_ctrl
//   Directed and randomized bench for inst_fetch_ctrl. The ROM returns its own
//   word index as the opcode. The reference model is simply "the next byte PC
//   the consumer should see": it starts at the reset PC, advances by 4 on each
//   accepted instruction and jumps to the aligned target on a redirect.
// -----------------------------------------------------------------------------
module tb_inst_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_opcode;

  logic        fetch_en_w;
  logic [31:0] rom_addr_w;
  logic [31:0] rom_data_w;
  logic        inst_valid_w;
  logic [31:0] inst_pc_w;
  logic [31:0] inst_opcode_w;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  logic [31:0] perf_fetch_cnt_w, perf_stall_cnt_w;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] next_exp_pc;

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_pc        (inst_pc),
    .inst_opcode    (inst_opcode)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en_w),
    .redirect_valid (1'b0),
    .redirect_pc    (32'd0),
    .rom_addr       (rom_addr_w),
    .rom_data       (rom_data_w),
    .inst_valid     (inst_valid_w),
    .inst_ready     (1'b1),
    .inst_pc        (inst_pc_w),
    .inst_opcode    (inst_opcode_w)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt_w),
    .perf_stall_cnt (perf_stall_cnt_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM, ROM[i] = i.
  always @(posedge clk) begin
    rom_data   <= rom_addr;
    rom_data_w <= rom_addr_w;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One consumer cycle: apply inputs after the falling edge, let the
  // combinational outputs settle, then score any accepted instruction.
  task automatic drive(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
    @(negedge clk);
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    inst_ready     = rdy;
    #1;
    if (rv) begin
      check("redirect_masks_valid", 32'(inst_valid), 32'd0);
      next_exp_pc = {rpc[31:2], 2'b00};
      $display("redirect to %h", next_exp_pc);
    end else if (inst_valid && rdy) begin
      check("deliver_pc", inst_pc, next_exp_pc);
      check("deliver_opcode", inst_opcode, {2'b00, next_exp_pc[31:2]});
      $display("deliver pc=%h opcode=%h", inst_pc, inst_opcode);
      next_exp_pc = next_exp_pc + 32'd4;
    end
  endtask

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    inst_ready     = 1'b0;
    fetch_en_w     = 1'b0;
    next_exp_pc    = 32'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_pc", inst_pc, 32'd0);
    check("rst_opcode", inst_opcode, 32'd0);
    check("rst_rom_addr", rom_addr, 32'd0);
    check("rst_rom_addr_w", rom_addr_w, 32'h3FFF_FFFE);
    check("rst_valid_w", 32'(inst_valid_w), 32'd0);
    rst = 1'b0;

    // Streaming: first valid two cycles after fetch_en, then one per cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      check("stream_valid", 32'(inst_valid), (i >= 2) ? 32'd1 : 32'd0);
    end

    // Backpressure: FIFO fills, PC stops, head held
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b0);
      check("bp_valid", 32'(inst_valid), 32'd1);
      check("bp_head_pc", inst_pc, next_exp_pc);
      check("bp_head_opcode", inst_opcode, {2'b00, next_exp_pc[31:2]});
      check("bp_no_issue", rom_addr, (next_exp_pc + 32'd8) >> 2);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      check("bp_release_valid", 32'(inst_valid), 32'd1);
    end

    // Redirect with a read in flight
    drive(1'b1, 1'b1, 32'h0000_0103, 1'b1);
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_first_issue", rom_addr, 32'h0000_0040);
    check("redir_no_stale", 32'(inst_valid), 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_no_stale2", 32'(inst_valid), 32'd0);
    drive(1'b1, 1'b0, 32'd0, 1'b1);
    check("redir_target_pc", inst_pc, 32'h0000_0100);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 32'd0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 80; i++) begin
      drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
            ($urandom & 32'h0000_0FFF), 1'($urandom_range(0, 1)));
    end

    // fetch_en low: in-flight read lands, FIFO drains, nothing lost
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 32'd0, 1'b1);
    check("drain_empty", 32'(inst_valid), 32'd0);
    check("drain_pc_consistent", rom_addr, next_exp_pc >> 2);

    // Async reset between edges with the FIFO full
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 32'd0, 1'b0);
    check("full_before_rst", 32'(inst_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(inst_valid), 32'd0);
    check("async_rst_pc", inst_pc, 32'd0);
    check("async_rst_rom_addr", rom_addr, 32'd0);
    @(negedge clk);
    fetch_en   = 1'b0;
    inst_ready = 1'b1;
    rst        = 1'b0;
    next_exp_pc = 32'd0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 32'd0, 1'b1);
      check("post_rst_valid", 32'(inst_valid), (i >= 2) ? 32'd1 : 32'd0);
      if (i == 2) check("post_rst_first_pc", inst_pc, 32'd0);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 32'd0, 1'b1);

    // PC wrap-around on the second instance
    @(negedge clk);
    fetch_en_w = 1'b1;
    for (int k = 0; k < 5; k++) begin
      logic [31:0] wpc;
      #1;
      if (k < 2) begin
        check("wrap_valid_lat", 32'(inst_valid_w), 32'd0);
      end else begin
        wpc = 32'hFFFF_FFF8 + 32'(4 * (k - 2));
        check("wrap_valid", 32'(inst_valid_w), 32'd1);
        check("wrap_pc", inst_pc_w, wpc);
        check("wrap_opcode", inst_opcode_w, wpc >> 2);
        $display("wrap pc=%h opcode=%h", inst_pc_w, inst_opcode_w);
      end
      @(negedge clk);
    end
    fetch_en_w = 1'b0;

`ifdef FETCH_PERF_CNT_EN
    // 10 issued reads, then 3 stalled cycles
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    next_exp_pc = 32'd0;
    check("perf_rst_fetch", perf_fetch_cnt, 32'd0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 32'd0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'd0, 1'b1);
    check("perf_fetch_cnt", perf_fetch_cnt, 32'd10);
    check("perf_stall_cnt", perf_stall_cnt, 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 SHALL provide port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1: asynchronous, active-high reset.
REQ-004 SHALL provide port fetch_en  input  1: when high, new ROM reads may issue.
REQ-005 SHALL provide port redirect_valid  input  1: one-cycle pulse that loads a new fetch PC.
REQ-006 SHALL provide port redirect_pc  input  32: byte address for the redirect.
REQ-007 SHALL provide port rom_addr  output  32: word address to the instruction ROM, {2'b00, pc[31:2]}.
REQ-008 SHALL provide port rom_data  input  32: ROM opcode, valid in the cycle after the address was captured.
REQ-009 SHALL provide port inst_valid  output  1: an instruction is presented.
REQ-010 SHALL provide port inst_ready  input  1: the consumer accepts the instruction.
REQ-011 SHALL provide port inst_pc  output  32: byte PC of the presented instruction.
REQ-012 SHALL provide port inst_opcode  output  32: opcode of the presented instruction.

Function
REQ-013 SHALL hold a byte PC register, a 2-entry FIFO of {pc, opcode}, and an in-flight flag for the single outstanding ROM read.
REQ-014 SHALL use two states, IDLE and RUN: IDLE->RUN when fetch_en=1; RUN->IDLE when fetch_en=0 and no read is in flight.
REQ-015 SHALL issue a read in a cycle only when fetch_en=1, redirect_valid=0, and (count + inflight - deq) < 2, where deq = inst_valid & inst_ready.
REQ-016 SHALL, on issue, drive rom_addr from the current PC, set inflight at the edge, and advance PC by 4 with 32-bit wrap-around (FFFF_FFFC -> 0000_0000).
REQ-017 SHALL, in the cycle after an issue, write {issued pc, rom_data} into the FIFO; on a simultaneous enqueue and dequeue, count SHALL stay unchanged.
REQ-018 SHALL drive inst_valid = (count != 0) & ~redirect_valid, and present the FIFO head on inst_pc and inst_opcode.
REQ-019 SHALL sustain one instruction per cycle in steady state while inst_ready=1 (first inst_valid 2 cycles after fetch_en rises from reset).
REQ-020 SHALL hold inst_pc and inst_opcode stable while inst_valid=1 and inst_ready=0.
REQ-021 SHALL, on redirect_valid=1, clear the FIFO, discard any in-flight response in the next cycle, and load PC with {redirect_pc[31:2], 2'b00}; redirect SHALL take priority over issue, enqueue and dequeue.
REQ-022 SHALL issue the first read from the new PC in the cycle after a redirect, if the issue conditions hold.
REQ-023 SHALL, when fetch_en falls, stop issuing, complete any in-flight read into the FIFO, and keep draining the FIFO to the consumer.
REQ-024 SHALL never overflow the FIFO; count + inflight SHALL never exceed 2.

Reset
REQ-025 SHALL, on rst=1 and independent of clk, set PC=RESET_PC, count=0, inflight=0, state=IDLE, inst_valid=0, inst_pc=0, inst_opcode=0, rom_addr=RESET_PC>>2.
REQ-026 SHALL discard any in-flight response from before a reset asserted mid-operation.

Configuration
REQ-027 SHALL, with macro FETCH_PERF_CNT_EN defined, add output perf_fetch_cnt (32), incremented on every issued read, and output perf_stall_cnt (32), incremented each cycle with inst_valid=1 and inst_ready=0; both wrap, both reset to 0.
REQ-028 SHALL, without FETCH_PERF_CNT_EN, omit both counter ports and their logic; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover streaming: reset, fetch_en=1, inst_ready=1, ROM[i]=i -> inst_pc 0,4,8,... on consecutive cycles, opcodes 0,1,2,..., first valid 2 cycles after fetch_en.
REQ-030 SHALL cover backpressure: inst_ready=0 for 5 cycles mid-stream -> count reaches 2, no issue, head held stable; after release, no instruction lost or duplicated.
REQ-031 SHALL cover redirect: redirect_valid pulse with redirect_pc=0x0000_0103 while a read is in flight -> no stale instruction delivered; next inst_pc=0x0000_0100.
REQ-032 SHALL cover wrap: RESET_PC=0xFFFF_FFF8 -> inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-033 SHALL cover async reset: rst asserted between clock edges with FIFO full -> inst_valid=0 immediately; after release, refetch starts from RESET_PC.
REQ-034 SHALL cover counters (FETCH_PERF_CNT_EN): 10 issued reads with 3 stall cycles -> perf_fetch_cnt=10 and perf_stall_cnt=3.
